cmem_fill: RTL

- Line-fill engine directly downstream of the shared cache's external bus.
- Accepts a one-line miss request (b_addr_c / b_rd_c) and issues a single burst read on the narrow system memory bus.
- Assembles the returned beats into a full cache line and returns it with a one-cycle b_dv_c pulse.
- Serves exactly one outstanding fill at a time; no write-back path.

---
 rtl/cmem_fill_pkg.sv | 31 +++
 rtl/cmem_fill.sv | 117 +++++++++++
 2 files changed

// File: rtl/cmem_fill_pkg.sv
// Shared definitions for the cache line-fill engine.
// Holds the cache/memory-bus geometry defaults, the fill FSM state encoding and
// helpers that derive the beat count and beat-counter width from the geometry.
package cmem_fill_pkg;

    // Cache-side geometry (64-bit byte address, 64-byte lines).
    localparam int unsigned CacheBlkLen = 58;
    localparam int unsigned CacheLineW  = 512;

    // Narrow system memory bus.
    localparam int unsigned MemBeatW  = 64;
    localparam int unsigned BurstLenW = 8;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StBeat = 2'd2,
        StDone = 2'd3
    } fill_state_e;

    // Beats per cache line.
    function automatic int unsigned beats_f(input int unsigned line_w, input int unsigned beat_w);
        return line_w / beat_w;
    endfunction

    // Beat-counter width; at least one bit so a single-beat line still elaborates.
    function automatic int unsigned cnt_w_f(input int unsigned beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/cmem_fill.sv
// Cache line-fill engine.
// Takes one line-miss request from the cache, issues a single incrementing burst
// read on the memory bus, assembles the returned beats into a full line and hands
// it back with a one-cycle b_dv_c pulse. One fill outstanding at a time.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   b_addr_c, b_rd_c  cache-side line address and level fill request
//   b_rdata_c, b_dv_c assembled line and its single-cycle valid
//   fill_err          OR of all beat errors of the line, coincident with b_dv_c
//   m_addr, m_len     burst byte address and burst length (beats minus one)
//   m_req, m_gnt      burst request / grant handshake
//   m_rdata, m_dv     returned beat data and valid
//   m_err             beat error, qualified by m_dv
module cmem_fill
    import cmem_fill_pkg::*;
#(
    parameter int unsigned BLK_LEN = CacheBlkLen,
    parameter int unsigned LINE_W  = CacheLineW,
    parameter int unsigned BEAT_W  = MemBeatW
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [BLK_LEN-1:0]   b_addr_c,
    input  logic                 b_rd_c,
    output logic [LINE_W-1:0]    b_rdata_c,
    output logic                 b_dv_c,
    output logic [63:0]          m_addr,
    output logic [BurstLenW-1:0] m_len,
    output logic                 m_req,
    input  logic                 m_gnt,
    input  logic [BEAT_W-1:0]    m_rdata,
    input  logic                 m_dv,
    input  logic                 m_err,
    output logic                 fill_err
);

    localparam int unsigned BEATS = beats_f(LINE_W, BEAT_W);
    localparam int unsigned CNT_W = cnt_w_f(BEATS);
    localparam int unsigned OFF_W = 64 - BLK_LEN;

    localparam logic [CNT_W-1:0] LastBeat = CNT_W'(BEATS - 1);

    fill_state_e        state_q, state_d;
    logic [BLK_LEN-1:0] line_addr_q, line_addr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_acc_q, err_acc_d;
    logic [LINE_W-1:0]  line_q, line_d;

    always_comb begin
        state_d     = state_q;
        line_addr_d = line_addr_q;
        cnt_d       = cnt_q;
        err_acc_d   = err_acc_q;
        line_d      = line_q;

        unique case (state_q)
            StIdle: begin
                if (b_rd_c) begin
                    line_addr_d = b_addr_c;
                    state_d     = StReq;
                end
            end
            StReq: begin
                // m_dv is not sampled here, so a beat coincident with m_gnt or
                // leftovers of an aborted burst cannot land in the line.
                if (m_gnt) begin
                    cnt_d     = '0;
                    err_acc_d = 1'b0;
                    state_d   = StBeat;
                end
            end
            StBeat: begin
                if (m_dv) begin
                    // Errored beats are still stored; the error only flags the line.
                    line_d[cnt_q*BEAT_W +: BEAT_W] = m_rdata;
                    err_acc_d = err_acc_q | m_err;
                    if (cnt_q == LastBeat) begin
                        state_d = StDone;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            line_addr_q <= '0;
            cnt_q       <= '0;
            err_acc_q   <= 1'b0;
            line_q      <= '0;
        end else begin
            state_q     <= state_d;
            line_addr_q <= line_addr_d;
            cnt_q       <= cnt_d;
            err_acc_q   <= err_acc_d;
            line_q      <= line_d;
        end
    end

    assign m_addr    = {line_addr_q, {OFF_W{1'b0}}};
    assign m_len     = BurstLenW'(BEATS - 1);
    assign m_req     = (state_q == StReq);
    assign b_dv_c    = (state_q == StDone);
    assign b_rdata_c = line_q;
    assign fill_err  = b_dv_c & err_acc_q;

endmodule
